// File: rtl/axi_mem_if_pkg.sv
// Shared types for the read/write memory arbiter: priority state and owner encoding.
package axi_mem_if_pkg;

  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } prio_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_RD   = 2'b01;
  localparam logic [1:0] OWNER_WR   = 2'b10;

endpackage

// File: rtl/axi_mem_rw_arbiter_if.sv
// Bundle of the two controller ports, the shared memory port and the owner flag.
// The master side is everything around the arbiter (controllers plus memory); the slave side is the arbiter.
interface axi_mem_rw_arbiter_if #(
  parameter int MEM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH / 8
);
  logic                      rd_valid_i;
  logic                      wr_valid_i;
  logic                      rd_grant_o;
  logic                      wr_grant_o;

  logic                      rd_cen_i;
  logic                      rd_wen_i;
  logic [MEM_ADDR_WIDTH-1:0] rd_a_i;
  logic [DATA_WIDTH-1:0]     rd_d_i;
  logic [BE_WIDTH-1:0]       rd_be_i;
  logic                      wr_cen_i;
  logic                      wr_wen_i;
  logic [MEM_ADDR_WIDTH-1:0] wr_a_i;
  logic [DATA_WIDTH-1:0]     wr_d_i;
  logic [BE_WIDTH-1:0]       wr_be_i;

  logic [DATA_WIDTH-1:0]     rd_q_o;
  logic [DATA_WIDTH-1:0]     wr_q_o;

  logic                      mem_cen_o;
  logic                      mem_wen_o;
  logic [MEM_ADDR_WIDTH-1:0] mem_a_o;
  logic [DATA_WIDTH-1:0]     mem_d_o;
  logic [BE_WIDTH-1:0]       mem_be_o;
  logic [DATA_WIDTH-1:0]     mem_q_i;

  logic [1:0]                owner_q_o;

  modport master (
    output rd_valid_i, wr_valid_i,
    output rd_cen_i, rd_wen_i, rd_a_i, rd_d_i, rd_be_i,
    output wr_cen_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
    output mem_q_i,
    input  rd_grant_o, wr_grant_o, rd_q_o, wr_q_o,
    input  mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o,
    input  owner_q_o
  );

  modport slave (
    input  rd_valid_i, wr_valid_i,
    input  rd_cen_i, rd_wen_i, rd_a_i, rd_d_i, rd_be_i,
    input  wr_cen_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
    input  mem_q_i,
    output rd_grant_o, wr_grant_o, rd_q_o, wr_q_o,
    output mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o,
    output owner_q_o
  );

endinterface

// File: rtl/axi_mem_rw_arbiter.sv
// Shares one single-port memory between a read and a write controller; grants are combinational,
// read data passes straight through, and contended access alternates after MAX_GRANTS wins in a row.
module axi_mem_rw_arbiter
  import axi_mem_if_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int MAX_GRANTS     = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  axi_mem_rw_arbiter_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_GRANTS - 1);

  prio_e                     r_prio;
  logic [7:0]                r_cnt;
  logic [1:0]                r_owner;

  logic                      w_contend;
  logic                      w_rd_grant;
  logic                      w_wr_grant;
  logic                      w_cen;
  logic                      w_wen;
  logic [MEM_ADDR_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0]     w_d;
  logic [BE_WIDTH-1:0]       w_be;

  assign w_contend  = bus.rd_valid_i & bus.wr_valid_i;
  assign w_rd_grant = bus.rd_valid_i & (!bus.wr_valid_i || (r_prio == PRIO_RD));
  assign w_wr_grant = bus.wr_valid_i & (!bus.rd_valid_i || (r_prio == PRIO_WR));

  // Idle cycles keep the read controller's address/data on the bus with the memory disabled.
  always_comb begin
    w_cen = 1'b1;
    w_wen = 1'b1;
    w_a   = bus.rd_a_i;
    w_d   = bus.rd_d_i;
    w_be  = bus.rd_be_i;
    if (w_wr_grant) begin
      w_cen = bus.wr_cen_i;
      w_wen = bus.wr_wen_i;
      w_a   = bus.wr_a_i;
      w_d   = bus.wr_d_i;
      w_be  = bus.wr_be_i;
    end else if (w_rd_grant) begin
      w_cen = bus.rd_cen_i;
      w_wen = bus.rd_wen_i;
    end
  end

  assign bus.rd_grant_o = w_rd_grant;
  assign bus.wr_grant_o = w_wr_grant;
  assign bus.mem_cen_o  = w_cen;
  assign bus.mem_wen_o  = w_wen;
  assign bus.mem_a_o    = w_a;
  assign bus.mem_d_o    = w_d;
  assign bus.mem_be_o   = w_be;
  assign bus.rd_q_o     = bus.mem_q_i;
  assign bus.wr_q_o     = bus.mem_q_i;
  assign bus.owner_q_o  = r_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio  <= PRIO_RD;
      r_cnt   <= '0;
      r_owner <= OWNER_NONE;
    end else begin
      r_owner <= w_wr_grant ? OWNER_WR : (w_rd_grant ? OWNER_RD : OWNER_NONE);
      // Any uncontended cycle breaks the streak but leaves priority where it is.
      if (!w_contend) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_prio <= (r_prio == PRIO_RD) ? PRIO_WR : PRIO_RD;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_rw_arbiter.sv
// Randomised and directed checks of the read/write memory arbiter against a win-streak reference model.
module tb_axi_mem_rw_arbiter;
  import axi_mem_if_pkg::*;

  localparam int AW   = 13;
  localparam int DW   = 64;
  localparam int BW   = 8;
  localparam int MAXG = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: which master is favoured and how many contended wins it has had in a row.
  bit         m_favour_wr;
  int         m_streak;
  logic [1:0] m_owner;

  axi_mem_rw_arbiter_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

  axi_mem_rw_arbiter #(
    .MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_GRANTS(MAXG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Returns {rd_grant, wr_grant}.
  function automatic logic [1:0] exp_grant(input logic rv, input logic wv);
    if (rv && wv) return m_favour_wr ? 2'b01 : 2'b10;
    return {rv, wv};
  endfunction

  task automatic model_reset();
    m_favour_wr = 1'b0;
    m_streak    = 0;
    m_owner     = OWNER_NONE;
  endtask

  task automatic idle_inputs();
    bus.rd_valid_i = 1'b0;
    bus.wr_valid_i = 1'b0;
    bus.rd_cen_i   = 1'b1;
    bus.rd_wen_i   = 1'b1;
    bus.rd_a_i     = '0;
    bus.rd_d_i     = '0;
    bus.rd_be_i    = '0;
    bus.wr_cen_i   = 1'b1;
    bus.wr_wen_i   = 1'b1;
    bus.wr_a_i     = '0;
    bus.wr_d_i     = '0;
    bus.wr_be_i    = '0;
    bus.mem_q_i    = '0;
  endtask

  // Advance one clock and update the model with the request seen before the edge.
  task automatic tick();
    logic [1:0] g;
    logic       both;
    g    = exp_grant(bus.rd_valid_i, bus.wr_valid_i);
    both = bus.rd_valid_i && bus.wr_valid_i;
    @(posedge clk);
    m_owner = g[1] ? OWNER_RD : (g[0] ? OWNER_WR : OWNER_NONE);
    if (both) begin
      m_streak++;
      if (m_streak == MAXG) begin
        m_favour_wr = !m_favour_wr;
        m_streak    = 0;
      end
    end else begin
      m_streak = 0;
    end
    #1;
  endtask

  // Called mid-cycle; does not cross a clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #3;
    checks++;
    if (bus.owner_q_o !== OWNER_NONE) begin
      errors++; $display("FAIL reset_owner: got %b expected %b", bus.owner_q_o, OWNER_NONE);
    end
    checks++;
    if ({bus.rd_grant_o, bus.wr_grant_o, bus.mem_cen_o, bus.mem_wen_o} !== 4'b0011) begin
      errors++; $display("FAIL reset_idle_port: got %b expected 0011",
                         {bus.rd_grant_o, bus.wr_grant_o, bus.mem_cen_o, bus.mem_wen_o});
    end
    bus.rd_valid_i = 1'b1;
    bus.wr_valid_i = 1'b1;
    #1;
    checks++;
    if ({bus.rd_grant_o, bus.wr_grant_o} !== 2'b10) begin
      errors++; $display("FAIL reset_grant_in_reset: got %b expected 10", {bus.rd_grant_o, bus.wr_grant_o});
    end
    idle_inputs();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rd_only();
    logic [DW-1:0] q;
    pulse_reset();
    bus.rd_valid_i = 1'b1;
    bus.rd_cen_i   = 1'b0;
    bus.rd_wen_i   = 1'b1;
    bus.rd_a_i     = 13'h010;
    bus.wr_cen_i   = 1'b0;
    bus.wr_a_i     = 13'h1abc;
    #1;
    checks++;
    if ({bus.rd_grant_o, bus.wr_grant_o} !== 2'b10) begin
      errors++; $display("FAIL rd_only_grant: got %b expected 10", {bus.rd_grant_o, bus.wr_grant_o});
    end
    checks++;
    if ({bus.mem_cen_o, bus.mem_a_o} !== {1'b0, 13'h010}) begin
      errors++; $display("FAIL rd_only_port: got cen=%b a=%h expected cen=0 a=010", bus.mem_cen_o, bus.mem_a_o);
    end
    tick();
    idle_inputs();
    q = {$urandom, $urandom};
    bus.mem_q_i = q;
    #1;
    checks++;
    if (bus.owner_q_o !== OWNER_RD) begin
      errors++; $display("FAIL rd_only_owner: got %b expected %b", bus.owner_q_o, OWNER_RD);
    end
    checks++;
    if ({bus.rd_q_o, bus.wr_q_o} !== {q, q}) begin
      errors++; $display("FAIL rd_only_q: got rd=%h wr=%h expected %h", bus.rd_q_o, bus.wr_q_o, q);
    end
    tick();
  endtask

  task automatic test_wr_only();
    idle_inputs();
    bus.wr_valid_i = 1'b1;
    bus.wr_cen_i   = 1'b0;
    bus.wr_wen_i   = 1'b0;
    bus.wr_be_i    = 8'hFF;
    bus.wr_d_i     = 64'hDEAD;
    bus.wr_a_i     = 13'h0555;
    bus.rd_cen_i   = 1'b0;
    #1;
    checks++;
    if ({bus.rd_grant_o, bus.wr_grant_o} !== 2'b01) begin
      errors++; $display("FAIL wr_only_grant: got %b expected 01", {bus.rd_grant_o, bus.wr_grant_o});
    end
    checks++;
    if ({bus.mem_cen_o, bus.mem_wen_o, bus.mem_be_o, bus.mem_d_o, bus.mem_a_o} !==
        {1'b0, 1'b0, 8'hFF, 64'hDEAD, 13'h0555}) begin
      errors++; $display("FAIL wr_only_port: got cen=%b wen=%b be=%h d=%h a=%h expected 0 0 ff dead 0555",
                         bus.mem_cen_o, bus.mem_wen_o, bus.mem_be_o, bus.mem_d_o, bus.mem_a_o);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.owner_q_o !== OWNER_WR) begin
      errors++; $display("FAIL wr_only_owner: got %b expected %b", bus.owner_q_o, OWNER_WR);
    end
    tick();
  endtask

  task automatic test_alternation();
    string pat;
    pat = "RRRRWWWWRRRR";
    pulse_reset();
    bus.rd_valid_i = 1'b1;
    bus.wr_valid_i = 1'b1;
    for (int i = 0; i < pat.len(); i++) begin
      #1;
      checks++;
      if ({bus.rd_grant_o, bus.wr_grant_o} !== ((pat[i] == "R") ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL alternation[%0d]: got %b expected %s", i, {bus.rd_grant_o, bus.wr_grant_o}, pat[i]);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_cnt_clear();
    string pat;
    string wrv;
    pat = "RRRRRRRW";
    wrv = "11011111";
    pulse_reset();
    for (int i = 0; i < pat.len(); i++) begin
      bus.rd_valid_i = 1'b1;
      bus.wr_valid_i = (wrv[i] == "1");
      #1;
      checks++;
      if ({bus.rd_grant_o, bus.wr_grant_o} !== ((pat[i] == "R") ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL cnt_clear[%0d]: got %b expected %s", i, {bus.rd_grant_o, bus.wr_grant_o}, pat[i]);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    bus.rd_valid_i = 1'b1;
    bus.wr_valid_i = 1'b1;
    for (int i = 0; i < MAXG + 1; i++) tick();
    checks++;
    if ({bus.rd_grant_o, bus.wr_grant_o, bus.owner_q_o} !== {2'b01, OWNER_WR}) begin
      errors++; $display("FAIL reset_mid_pre: got grants=%b owner=%b expected 01 10",
                         {bus.rd_grant_o, bus.wr_grant_o}, bus.owner_q_o);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.owner_q_o !== OWNER_NONE) begin
      errors++; $display("FAIL reset_mid_owner: got %b expected 00", bus.owner_q_o);
    end
    checks++;
    if ({bus.rd_grant_o, bus.wr_grant_o} !== 2'b10) begin
      errors++; $display("FAIL reset_mid_grant_in_reset: got %b expected 10", {bus.rd_grant_o, bus.wr_grant_o});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.rd_grant_o, bus.wr_grant_o} !== 2'b10) begin
      errors++; $display("FAIL reset_mid_grant: got %b expected 10", {bus.rd_grant_o, bus.wr_grant_o});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_idle();
    string pat;
    logic [AW-1:0] a;
    pat = "WWWWR";
    pulse_reset();
    bus.rd_valid_i = 1'b1;
    bus.wr_valid_i = 1'b1;
    for (int i = 0; i < MAXG; i++) tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      a = AW'($urandom);
      bus.rd_a_i   = a;
      bus.rd_cen_i = 1'b0;
      bus.wr_cen_i = 1'b0;
      #1;
      checks++;
      if ({bus.rd_grant_o, bus.wr_grant_o, bus.mem_cen_o, bus.mem_wen_o, bus.mem_a_o} !== {4'b0011, a}) begin
        errors++; $display("FAIL idle[%0d]: got g=%b cen=%b wen=%b a=%h expected 00 1 1 %h", i,
                           {bus.rd_grant_o, bus.wr_grant_o}, bus.mem_cen_o, bus.mem_wen_o, bus.mem_a_o, a);
      end
      tick();
      checks++;
      if (bus.owner_q_o !== OWNER_NONE) begin
        errors++; $display("FAIL idle_owner[%0d]: got %b expected 00", i, bus.owner_q_o);
      end
    end
    bus.rd_valid_i = 1'b1;
    bus.wr_valid_i = 1'b1;
    for (int i = 0; i < pat.len(); i++) begin
      #1;
      checks++;
      if ({bus.rd_grant_o, bus.wr_grant_o} !== ((pat[i] == "R") ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL idle_resume[%0d]: got %b expected %s", i, {bus.rd_grant_o, bus.wr_grant_o}, pat[i]);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [1:0]        g;
    logic [1:0]        exp_owner;
    logic [DW-1:0]     q;
    logic [AW+DW+BW+1:0] exp_port;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      bus.rd_valid_i = ($urandom_range(0, 3) != 0);
      bus.wr_valid_i = ($urandom_range(0, 3) != 0);
      bus.rd_cen_i   = 1'($urandom);
      bus.rd_wen_i   = 1'($urandom);
      bus.rd_a_i     = AW'($urandom);
      bus.rd_d_i     = {$urandom, $urandom};
      bus.rd_be_i    = BW'($urandom);
      bus.wr_cen_i   = 1'($urandom);
      bus.wr_wen_i   = 1'($urandom);
      bus.wr_a_i     = AW'($urandom);
      bus.wr_d_i     = {$urandom, $urandom};
      bus.wr_be_i    = BW'($urandom);
      q              = {$urandom, $urandom};
      bus.mem_q_i    = q;
      #1;
      g = exp_grant(bus.rd_valid_i, bus.wr_valid_i);
      if (g[0])      exp_port = {bus.wr_cen_i, bus.wr_wen_i, bus.wr_a_i, bus.wr_d_i, bus.wr_be_i};
      else if (g[1]) exp_port = {bus.rd_cen_i, bus.rd_wen_i, bus.rd_a_i, bus.rd_d_i, bus.rd_be_i};
      else           exp_port = {1'b1, 1'b1, bus.rd_a_i, bus.rd_d_i, bus.rd_be_i};
      checks++;
      if ({bus.rd_grant_o, bus.wr_grant_o} !== g) begin
        errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", i, {bus.rd_grant_o, bus.wr_grant_o}, g);
      end
      checks++;
      if ({bus.mem_cen_o, bus.mem_wen_o, bus.mem_a_o, bus.mem_d_o, bus.mem_be_o} !== exp_port) begin
        errors++; $display("FAIL rand_port[%0d]: got %h expected %h", i,
                           {bus.mem_cen_o, bus.mem_wen_o, bus.mem_a_o, bus.mem_d_o, bus.mem_be_o}, exp_port);
      end
      checks++;
      if ({bus.rd_q_o, bus.wr_q_o} !== {q, q}) begin
        errors++; $display("FAIL rand_q[%0d]: got rd=%h wr=%h expected %h", i, bus.rd_q_o, bus.wr_q_o, q);
      end
      tick();
      exp_owner = m_owner;
      checks++;
      if (bus.owner_q_o !== exp_owner) begin
        errors++; $display("FAIL rand_owner[%0d]: got %b expected %b", i, bus.owner_q_o, exp_owner);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_rd_only();
    test_wr_only();
    test_alternation();
    test_cnt_clear();
    test_reset_mid();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
